// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART receiver: circular storage,
// occupancy/almost-full status and a sticky overrun flag for dropped words.
module uart_rx_fifo #(
  parameter int unsigned DBITS        = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [DBITS-1:0]           i_wr_data,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic [DBITS-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_afull,
  output logic                       o_overrun,
  input  logic                       i_ovr_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;

  logic empty_c, full_c, rd_fire_c, wr_accept_c;

  // Status is decoded straight from the registered occupancy
  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CW'(DEPTH));
  assign rd_fire_c   = ~empty_c & i_rd_ready;
  assign wr_accept_c = i_wr_en & (~full_c | rd_fire_c);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_accept_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire_c)   rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_accept_c, rd_fire_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped write sets the flag even when a clear arrives in the same cycle
    if (i_ovr_clr)                 overrun_d = 1'b0;
    if (i_wr_en && !wr_accept_c)   overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is intentionally left unreset
  always_ff @(posedge i_clk) begin
    if (wr_accept_c) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_valid = ~empty_c;
  assign o_rd_data  = empty_c ? '0 : mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_empty    = empty_c;
  assign o_full     = full_c;
  assign o_afull    = (count_q >= CW'(AFULL_THRESH));
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer.
module tb_uart_rx_fifo;

  localparam int unsigned DBITS = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_wr_en;
  logic [DBITS-1:0] i_wr_data;
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic [DBITS-1:0] o_rd_data;
  logic [CW-1:0]    o_count;
  logic             o_empty;
  logic             o_full;
  logic             o_afull;
  logic             o_overrun;
  logic             i_ovr_clr;

  uart_rx_fifo #(.DBITS(DBITS), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_afull    (o_afull),
    .o_overrun  (o_overrun),
    .i_ovr_clr  (i_ovr_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic [DBITS-1:0] mq[$];
  logic             m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int unsigned sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(o_count), sz);
    chk({tag, ".empty"}, 32'(o_empty), 32'(sz == 0));
    chk({tag, ".full"},  32'(o_full),  32'(sz == DEPTH));
    chk({tag, ".afull"}, 32'(o_afull), 32'(sz >= AFULL));
    chk({tag, ".valid"}, 32'(o_rd_valid), 32'(sz != 0));
    chk({tag, ".data"},  32'(o_rd_data), (sz != 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".ovr"},   32'(o_overrun), 32'(m_ovr));
  endtask

  // One clock of stimulus; reference model advances at the edge, outputs checked #1 later
  task automatic step(input logic wr, input logic [DBITS-1:0] d, input logic rd,
                      input logic clr, input string tag);
    bit valid, fire, wa;
    i_wr_en    = wr;
    i_wr_data  = d;
    i_rd_ready = rd;
    i_ovr_clr  = clr;
    @(posedge i_clk);
    valid = (mq.size() != 0);
    fire  = valid && rd;
    wa    = wr && ((mq.size() < DEPTH) || fire);
    if (fire) void'(mq.pop_front());
    if (wa)   mq.push_back(d);
    m_ovr = (m_ovr && !clr) || (wr && !wa);
    #1;
    i_wr_en    = 1'b0;
    i_rd_ready = 1'b0;
    i_ovr_clr  = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_wr_en    = 1'b0;
    i_wr_data  = '0;
    i_rd_ready = 1'b0;
    i_ovr_clr  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Single word: FWFT visible one edge after the write
    step(1'b1, 8'hA5, 1'b0, 1'b0, "wr_a5");
    chk("a5_data", 32'(o_rd_data), 32'hA5);
    chk("a5_count", 32'(o_count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "rd_a5");
    chk("a5_empty", 32'(o_empty), 32'd1);

    // Fill/drain three times to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        if (i == 10) chk("afull_lo", 32'(o_afull), 32'd0);
        if (i == 11) chk("afull_hi", 32'(o_afull), 32'd1);
        if (i == 14) chk("full_lo",  32'(o_full),  32'd0);
      end
      chk("full_hi", 32'(o_full), 32'd1);
      for (int i = 0; i < 16; i++) begin
        chk("rd_order", 32'(o_rd_data), 32'(i));
        step(1'b0, '0, 1'b1, 1'b0, "drain");
      end
    end

    // Overflow: dropped word, sticky flag, clear
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill_ovr");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "drop_ee");
    chk("drop_count", 32'(o_count), 32'd16);
    chk("drop_ovr", 32'(o_overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovr_order", 32'(o_rd_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, "drain_ovr");
    end
    chk("ovr_sticky", 32'(o_overrun), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "ovr_clr");
    chk("ovr_cleared", 32'(o_overrun), 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill_sim");
    step(1'b1, 8'h77, 1'b1, 1'b0, "sim_rw");
    chk("sim_count", 32'(o_count), 32'd16);
    chk("sim_ovr", 32'(o_overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("sim_order", 32'(o_rd_data), (i == 15) ? 32'h77 : 32'(8'h11 + i));
      step(1'b0, '0, 1'b1, 1'b0, "drain_sim");
    end

    // Clear coinciding with a dropped write: set wins
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill_clr");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "drop1");
    step(1'b1, 8'h55, 1'b0, 1'b1, "drop_clr");
    chk("set_wins", 32'(o_overrun), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, "drain_clr");

    // Asynchronous reset mid-stream with five words held
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
    chk("pre_rst_count", 32'(o_count), 32'd5);
    #2;
    i_rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    chk_all("async_rst");
    chk("rst_count", 32'(o_count), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, "post_rst");
    step(1'b1, 8'h99, 1'b0, 1'b0, "post_rst2");
    chk("post_rst_first", 32'(o_rd_data), 32'h3C);

    // Random traffic in phases biased towards filling or draining
    for (int n = 0; n < 3000; n++) begin
      int unsigned wp;
      wp = ((n / 200) % 2 == 0) ? 70 : 35;
      step(1'($urandom_range(99) < wp), 8'($urandom),
           1'($urandom_range(99) >= wp), 1'($urandom_range(19) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received word on the receiver's single-cycle done pulse and holds it in a circular buffer. Words are presented to the host/bus side through a first-word-fall-through valid/ready interface. It reports fill level, almost-full and a sticky overrun flag, so software can drain the buffer at its own pace without losing characters silently.

Parameters:
DBITS, 8, data word width; matches the receiver's data width.
DEPTH, 16, number of storage entries; power of two, >= 2.
AFULL_THRESH, 12, o_afull asserts when occupancy >= this value; range 1..DEPTH.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_wr_en  input  1  write strobe; connected to the receiver done pulse; one word per high cycle
i_wr_data  input  DBITS  word to store; sampled when i_wr_en=1
o_rd_valid  output  1  head word available on o_rd_data
i_rd_ready  input  1  consumer accepts head word when o_rd_valid=1
o_rd_data  output  DBITS  head word (FWFT); 0 when empty
o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_empty  output  1  occupancy == 0
o_full  output  1  occupancy == DEPTH
o_afull  output  1  occupancy >= AFULL_THRESH
o_overrun  output  1  sticky: a write was dropped because the buffer was full
i_ovr_clr  input  1  single-cycle clear of o_overrun

Behaviour:
- Reset (async, i_rst_n=0): wr_ptr=0, rd_ptr=0, count=0, overrun=0. Outputs: o_rd_valid=0, o_rd_data=0, o_count=0, o_empty=1, o_full=0, o_afull=0, o_overrun=0. Storage array is not reset. Reset mid-operation discards all contents immediately.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with natural overflow. Occupancy is held in an explicit count register, not derived from the pointers.
- Write accept (wa) = i_wr_en & (~o_full | rd_fire). Read fire (rd_fire) = o_rd_valid & i_rd_ready.
- On wa: mem[wr_ptr] <= i_wr_data and wr_ptr += 1. On rd_fire: rd_ptr += 1.
- Count update: +1 on wa only, -1 on rd_fire only, unchanged when both or neither occur.
- FWFT latency: a word written into an empty FIFO at edge N sets o_rd_valid=1 with that word on o_rd_data after edge N. The word is visible in the same cycle the count becomes 1; o_rd_data = mem[rd_ptr] whenever count>0.
- o_rd_valid = ~o_empty. Read with o_rd_valid=0 is ignored; no pointer change.
- Full and simultaneous read + write: both proceed, count stays DEPTH, no overrun.
- Full and write without read: word dropped, pointers and count unchanged, overrun <= 1 at the same edge.
- Empty and simultaneous i_wr_en + i_rd_ready: write only; no read, because valid is low.
- Overrun is sticky until i_ovr_clr=1. If a clear and a new dropped write occur in the same cycle, the set wins and o_overrun stays 1.
- All status outputs (o_empty, o_full, o_afull, o_count) are combinational from registered count. They update in the cycle after the causing edge and carry no extra latency.
- The block is purely synchronous to i_clk. i_wr_en is assumed to be a single-cycle pulse from the receiver in the same clock domain; back-to-back pulses are nevertheless supported every cycle.

Test Plan:
- Reset then idle -> o_empty=1, o_rd_valid=0, o_count=0, o_rd_data=0, o_overrun=0 for 20 cycles.
- Write 0xA5 with i_rd_ready=0 -> next cycle o_rd_valid=1, o_rd_data=0xA5, o_count=1. Assert i_rd_ready one cycle -> o_empty=1, o_count=0.
- Write 16 words 0x00..0x0F, then read with i_rd_ready=1 -> o_afull rises at count 12, o_full at 16. Reads return 0x00..0x0F in order. Repeat 3 times to exercise pointer wrap.
- Fill to 16, then write 0xEE with no read -> 0xEE dropped, o_count=16, o_overrun=1. Drain -> last word 0x0F. o_overrun stays 1 until i_ovr_clr pulse, then 0.
- Full with simultaneous write 0x77 + read -> o_count stays 16, o_overrun=0. 0x77 appears as the 16th subsequent read. Also drive i_ovr_clr concurrently with a dropped write -> o_overrun=1.
- Assert i_rst_n=0 mid-stream with count=5 -> outputs return to reset values asynchronously. After release, the first new write 0x3C is the first word read.
